// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan decoder.
//
// Watches the active-low anode strobes and segment lines of a multiplexed
// seven-segment display, waits until {an_i,sseg_i} has been stable for
// STABLE_CYC consecutive samples, then decodes the pattern back into a hex
// digit for the strobed position.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   an_i       anode strobes, active low, one per position
//   sseg_i     segments, active low; [6:0]={g,f,e,d,c,b,a}, [7]=dp
//   err_clr_i  clears err_o (an error on the same edge wins)
//   digit_o    decoded hex value, position k at [4k+3:4k]
//   dp_o       decimal point lit, per position
//   blank_o    position showed all segments off
//   valid_o    position holds a legally decoded value or blank
//   update_o   one-cycle pulse when any digit/dp/blank field changes
//   frame_o    one-cycle pulse when every position has been captured
//   err_o      sticky error (illegal pattern or multi-anode overlap)
//
// State  | meaning
// SETTLE | sample changed recently; counting identical samples
// HOLD   | current sample already evaluated; waiting for a change
module sseg_scan_decoder #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DIG-1:0]   an_i,
    input  logic [7:0]           sseg_i,
    input  logic                 err_clr_i,
    output logic [4*NUM_DIG-1:0] digit_o,
    output logic [NUM_DIG-1:0]   dp_o,
    output logic [NUM_DIG-1:0]   blank_o,
    output logic [NUM_DIG-1:0]   valid_o,
    output logic                 update_o,
    output logic                 frame_o,
    output logic                 err_o
);

    localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_DIG+7:0]     samp, smp_q;
    logic [NUM_DIG-1:0]     seen_q, seen_d;

    logic [4*NUM_DIG-1:0]   digit_d;
    logic [NUM_DIG-1:0]     dp_d, blank_d, valid_d;
    logic                   upd_d, frm_d, err_d;

    logic                   same, eval;
    logic [NUM_DIG-1:0]     an_r, sel;
    logic [7:0]             sg_r;
    logic                   one_low, multi_low, is_blank, legal;
    logic [4:0]             dec;

    // Returns {legal, value} for an active-low segment pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // samp is what the input register is about to load; comparing it with
    // the current register is "new registered value == previous one".
    assign samp = {an_i, sseg_i};
    assign same = (samp == smp_q);

    assign an_r      = smp_q[NUM_DIG+7:8];
    assign sg_r      = smp_q[7:0];
    assign one_low   = ($countones(~an_r) == 1);
    assign multi_low = ($countones(~an_r) > 1);
    assign sel       = one_low ? ~an_r : '0;
    assign dec       = hex_decode(sg_r[6:0]);
    assign is_blank  = (sg_r[6:0] == 7'h7F);
    assign legal     = dec[4] | is_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            smp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smp_q   <= samp;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eval    = 1'b0;
        digit_d = digit_o;
        dp_d    = dp_o;
        blank_d = blank_o;
        valid_d = valid_o;
        seen_d  = seen_q;
        upd_d   = 1'b0;
        frm_d   = 1'b0;
        err_d   = err_o;

        // A change on the evaluation edge itself aborts the capture.
        if (!same) begin
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_MAX) begin
                eval    = 1'b1;
                state_d = HOLD;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        for (int i = 0; i < NUM_DIG; i++) begin
            if (eval && sel[i]) begin
                if (legal) begin
                    if (!is_blank) begin
                        digit_d[4*i +: 4] = dec[3:0];
                    end
                    dp_d[i]    = ~sg_r[7];
                    blank_d[i] = is_blank;
                    valid_d[i] = 1'b1;
                    seen_d[i]  = 1'b1;
                end else begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (eval && one_low && legal) begin
            upd_d = ({digit_d, dp_d, blank_d} != {digit_o, dp_o, blank_o});
            if (&seen_d) begin
                frm_d  = 1'b1;
                seen_d = '0;
            end
        end

        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (eval && (multi_low || (one_low && !legal))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_o  <= '0;
            dp_o     <= '0;
            blank_o  <= '0;
            valid_o  <= '0;
            seen_q   <= '0;
            update_o <= 1'b0;
            frame_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            digit_o  <= digit_d;
            dp_o     <= dp_d;
            blank_o  <= blank_d;
            valid_o  <= valid_d;
            seen_q   <= seen_d;
            update_o <= upd_d;
            frame_o  <= frm_d;
            err_o    <= err_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
module tb_sseg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [ND-1:0] an_i = '1;
    logic [7:0]    sseg_i = 8'hFF;
    logic          err_clr_i = 1'b0;
    logic [4*ND-1:0] digit_o;
    logic [ND-1:0] dp_o, blank_o, valid_o;
    logic          update_o, frame_o, err_o;

    int n_chk = 0;
    int n_fail = 0;

    sseg_scan_decoder #(.NUM_DIG(ND), .STABLE_CYC(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .an_i      (an_i),
        .sseg_i    (sseg_i),
        .err_clr_i (err_clr_i),
        .digit_o   (digit_o),
        .dp_o      (dp_o),
        .blank_o   (blank_o),
        .valid_o   (valid_o),
        .update_o  (update_o),
        .frame_o   (frame_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  sseg;
        logic        clr;
        logic [15:0] digit;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  valid;
        logic        upd;
        logic        chk_upd;
        logic        frm;
        logic        err;
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];
    vec_t prev;
    vec_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int upd_cnt;

    initial begin
        // an, sseg, clr, digit, dp, blank, valid, upd, chk_upd, frm, err
        vecs[0]  = '{4'b1110, 8'hC0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 8'hFF, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b1110, 8'hF9, 1'b0, 16'h0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b1101, 8'hA4, 1'b0, 16'h0021, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b1011, 8'hB0, 1'b0, 16'h0321, 4'b0000, 4'b0000, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0111, 8'h99, 1'b0, 16'h4321, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b1011, 8'h7F, 1'b0, 16'h4321, 4'b0100, 4'b0100, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'b1011, 8'hFE, 1'b0, 16'h4321, 4'b0100, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{4'b1111, 8'hFF, 1'b1, 16'h4321, 4'b0100, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b1100, 8'hC0, 1'b0, 16'h4321, 4'b0100, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{4'b1011, 8'h02, 1'b0, 16'h4621, 4'b0100, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{4'b1101, 8'h86, 1'b0, 16'h46E1, 4'b0100, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{4'b1110, 8'h8E, 1'b0, 16'h46EF, 4'b0100, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{4'b0111, 8'h99, 1'b0, 16'h46EF, 4'b0100, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1};

        prev = '{4'b1111, 8'hFF, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset digit", 32'(digit_o), 32'h0);
        chk("reset dp", 32'(dp_o), 32'h0);
        chk("reset blank", 32'(blank_o), 32'h0);
        chk("reset valid", 32'(valid_o), 32'h0);
        chk("reset update", 32'(update_o), 32'h0);
        chk("reset frame", 32'(frame_o), 32'h0);
        chk("reset err", 32'(err_o), 32'h0);
        rst = 1'b0;
        repeat (6) step();

        // Table: each vector held for edges 0..SC; capture expected at edge SC.
        for (int i = 0; i < 14; i++) begin
            an_i = vecs[i].an;
            sseg_i = vecs[i].sseg;
            err_clr_i = vecs[i].clr;
            exp_q.push_back(vecs[i]);
            step();
            err_clr_i = 1'b0;
            repeat (SC - 1) step();
            chk($sformatf("v%0d pre update", i), 32'(update_o), 32'h0);
            chk($sformatf("v%0d pre frame", i), 32'(frame_o), 32'h0);
            chk($sformatf("v%0d pre digit", i), 32'(digit_o), 32'(prev.digit));
            chk($sformatf("v%0d pre valid", i), 32'(valid_o), 32'(prev.valid));
            step();
            if (exp_q.size() == 0) begin
                chk($sformatf("v%0d scoreboard empty", i), 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("v%0d digit", i), 32'(digit_o), 32'(e.digit));
                chk($sformatf("v%0d dp", i), 32'(dp_o), 32'(e.dp));
                chk($sformatf("v%0d blank", i), 32'(blank_o), 32'(e.blank));
                chk($sformatf("v%0d valid", i), 32'(valid_o), 32'(e.valid));
                chk($sformatf("v%0d frame", i), 32'(frame_o), 32'(e.frm));
                chk($sformatf("v%0d err", i), 32'(err_o), 32'(e.err));
                if (e.chk_upd) begin
                    chk($sformatf("v%0d update", i), 32'(update_o), 32'(e.upd));
                end
                prev = e;
            end
        end

        // err_clr alone clears; then set-dominance with err_clr held.
        an_i = 4'hF; sseg_i = 8'hFF; err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("err clear", 32'(err_o), 32'h0);
        repeat (6) step();
        an_i = 4'b1100; sseg_i = 8'hC0; err_clr_i = 1'b1;
        repeat (SC) step();
        chk("err clr held pre", 32'(err_o), 32'h0);
        step();
        chk("err set dominant", 32'(err_o), 32'h1);
        err_clr_i = 1'b0;
        an_i = 4'hF; sseg_i = 8'hFF;
        repeat (6) step();

        // Glitch rejection on position 1.
        an_i = 4'b1101; sseg_i = 8'hA4;
        repeat (SC + 1) step();
        chk("glitch setup digit", 32'(digit_o[7:4]), 32'h2);
        chk("glitch setup update", 32'(update_o), 32'h1);
        repeat (3) step();
        upd_cnt = 0;
        sseg_i = 8'hB0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (update_o) upd_cnt++;
        end
        sseg_i = 8'hA4;
        for (int c = 0; c < 8; c++) begin
            step();
            if (update_o) upd_cnt++;
        end
        chk("glitch digit", 32'(digit_o[7:4]), 32'h2);
        chk("glitch updates", 32'(upd_cnt), 32'h0);

        // Change on the evaluation edge aborts the capture.
        an_i = 4'b1110; sseg_i = 8'hA4;
        repeat (SC) step();
        an_i = 4'hF; sseg_i = 8'hFF;
        upd_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (update_o) upd_cnt++;
        end
        chk("abort digit", 32'(digit_o[3:0]), 32'hF);
        chk("abort updates", 32'(upd_cnt), 32'h0);

        // Reset in the middle of a settle window.
        an_i = 4'b1110; sseg_i = 8'hF9;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst digit", 32'(digit_o), 32'h0);
        chk("midrst valid", 32'(valid_o), 32'h0);
        chk("midrst dp", 32'(dp_o), 32'h0);
        chk("midrst err", 32'(err_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (SC) step();
        chk("postrst early valid", 32'(valid_o), 32'h0);
        chk("postrst early digit", 32'(digit_o), 32'h0);
        step();
        chk("postrst digit", 32'(digit_o), 32'h0001);
        chk("postrst valid", 32'(valid_o), 32'h1);
        chk("postrst update", 32'(update_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive side of the multiplexed seven-segment display interface. Samples the active-low anode strobes and segment lines produced by the display driver, filters out the transition glitches, and converts each segment pattern back into a 4-bit hex digit per position.
- Used as an on-chip self-check monitor, and as the bench-side decoder for display-driving top levels.
- Flags illegal patterns and multi-anode overlap, and reports when every position has been refreshed.

Parameters:
- NUM_DIG, 4, number of anode positions monitored.
- STABLE_CYC, 16, number of consecutive samples for which {an_i,sseg_i} must be unchanged before a capture (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- an_i  in  NUM_DIG  anode strobes, active low.
- sseg_i  in  8  segments, active low; [6:0]={g,f,e,d,c,b,a}, [7]=dp.
- err_clr_i  in  1  clears err_o.
- digit_o  out  4*NUM_DIG  decoded hex value; position k at [4k+3:4k].
- dp_o  out  NUM_DIG  decimal point lit, per position.
- blank_o  out  NUM_DIG  position showed all segments off.
- valid_o  out  NUM_DIG  position holds a legally decoded value or blank.
- update_o  out  1  one-cycle pulse when any digit_o/dp_o/blank_o field changes.
- frame_o  out  1  one-cycle pulse when all positions have been captured since the last frame_o.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset values: digit_o=0, dp_o=0, blank_o=0, valid_o=0, update_o=0, frame_o=0, err_o=0. The stability counter, input register and seen-mask are all cleared, and the FSM enters SETTLE.
- Reset is asynchronous. Asserting rst mid-settle discards the pending sample; no capture may follow from pre-reset data.
- Input register: {an_i,sseg_i} is registered every edge. The sample at edge 0 is the first edge that sees a new value.
- FSM SETTLE:
  - The counter runs while the registered value equals the previous registered value.
  - On the edge completing STABLE_CYC identical samples (edges 0..STABLE_CYC-1), the FSM evaluates the sample.
  - Capture registers and pulses update on edge STABLE_CYC. The FSM then moves to HOLD.
- FSM HOLD:
  - No further captures occur while the value is unchanged.
  - Any change clears the counter and returns to SETTLE. A change on the same edge as capture evaluation aborts that capture.
- Evaluation of a stable sample:
  - All anodes high: no capture, no error (inter-digit blanking).
  - More than one anode low: err_o<=1, no field changes.
  - Exactly one anode k low, pattern legal: see the next two bullets.
  - Exactly one anode k low, pattern not in the hex table and not 7'h7F: valid_o[k]<=0 and err_o<=1. digit_o, dp_o and blank_o for k are held.
- Legal pattern on position k:
  - digit_o[k] is written from the decode table.
  - blank_o[k]<=(pattern==7'h7F); a blank capture leaves digit_o[k] unchanged.
  - dp_o[k]<=~sseg[7], valid_o[k]<=1, and bit k of the seen-mask is set.
- Decode table, value -> active-low pattern [6:0]:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- update_o pulses on the capture edge only if the written digit/dp/blank values differ from the prior values.
- frame_o pulses on the capture edge that completes the seen-mask (all ones). The seen-mask clears on that same edge.
- err_o:
  - Set-dominant: an error event on the same edge as err_clr_i leaves err_o=1.
  - Otherwise err_clr_i clears it on the next edge.
- The counter saturates at STABLE_CYC-1 and has no wrap-around.

Test Plan:
- STABLE_CYC=4: hold an_i=4'b1110, sseg_i=8'hC0 from edge 0 -> digit_o[3:0]=0, valid_o=4'b0001 and update_o pulse after edge 4; nothing changes before edge 4.
- Scan 1,2,3,4 (patterns 79,24,30,19) across positions 0..3, 8 cycles each with 2-cycle all-high gaps -> digit_o=16'h4321, valid_o=4'hF, one frame_o pulse on the position-3 capture, err_o=0.
- Glitch rejection: hold position 1 with pattern 24, insert a 2-cycle pattern 30 (STABLE_CYC=4) -> digit_o[7:4] stays 2, no update_o.
- an_i=4'b1100 stable for 4 cycles -> err_o=1, valid_o unchanged. Then err_clr_i for 1 cycle -> err_o=0.
- Position 2 with pattern 7F and dp low -> blank_o[2]=1, dp_o[2]=1, valid_o[2]=1. A following illegal pattern 7E -> valid_o[2]=0, err_o=1.
- Assert rst at cycle 2 of a settle window -> all outputs at reset values immediately; the re-held value captures STABLE_CYC edges after rst deasserts.
